gs_i2s_tx: RTL and testbench
============================

GS_I2S_TX -- requirements
Module: gs_i2s_tx

Interface
REQ-001 SHALL have parameter BCK_DIV, default 4: CLK cycles per BCK half-period; legal range 2..255.
REQ-002 SHALL have parameter GAIN, default 0: left-shift gain applied before attenuation, with saturation; legal range 0..2.
REQ-003 SHALL have port CLK  input  1  single system clock; all logic on its rising edge.
REQ-004 SHALL have port RESET  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port EN  input  1  run enable; low holds the block idle.
REQ-006 SHALL have port IN_L  input  15  signed left sample from the GS sound stage.
REQ-007 SHALL have port IN_R  input  15  signed right sample from the GS sound stage.
REQ-008 SHALL have port VOL  input  4  attenuation, arithmetic right-shift amount 0..15.
REQ-009 SHALL have port I2S_BCK  output  1  bit clock.
REQ-010 SHALL have port I2S_LRCK  output  1  word select; 0 = left, 1 = right.
REQ-011 SHALL have port I2S_DATA  output  1  serial data, MSB first.
REQ-012 SHALL have port SAMPLE_STB  output  1  one-CLK pulse on each sample capture.

Function
REQ-013 SHALL implement two states: IDLE and RUN.
REQ-014 SHALL, in IDLE, drive I2S_BCK, I2S_LRCK, I2S_DATA and SAMPLE_STB to 0, and hold the divider, bit counter and word registers at 0.
REQ-015 SHALL leave IDLE for RUN on the first CLK with EN=1; on that cycle it SHALL capture, pulse SAMPLE_STB, set bit counter n=0 and divider=0.
REQ-016 SHALL, in RUN with EN=0, return to IDLE on the next CLK edge, clearing per REQ-014; a partial frame is dropped.
REQ-017 SHALL, in RUN, increment the divider each CLK; at BCK_DIV-1 the divider wraps to 0 and I2S_BCK toggles.
REQ-018 SHALL, on each toggle where I2S_BCK goes 1->0 (falling event), advance the 6-bit bit counter n (63 wraps to 0).
REQ-019 SHALL, on a falling event where n wraps 63->0, capture and pulse SAMPLE_STB in that same CLK.
REQ-020 SHALL, on capture, latch IN_L, IN_R and VOL together, so left and right are always from the same CLK.
REQ-021 SHALL, on capture, produce each 16-bit word as: s = {IN,1'b0}; g = s shifted left by GAIN, saturated to [-32768, 32767]; word = g arithmetic-shifted right by VOL.
REQ-022 SHALL register I2S_LRCK and I2S_DATA and update them only on falling events and on IDLE->RUN entry, using the new value of n.
REQ-023 SHALL set I2S_LRCK = n[5].
REQ-024 SHALL set I2S_DATA from p = n[4:0]: for p in 1..16, bit (16-p) of the left word when n[5]=0, or of the right word when n[5]=1; for every other p, 0.
REQ-025 SHALL give a frame of 64 BCK periods, with sample rate = CLK/(128*BCK_DIV).
REQ-026 SHALL ignore input changes between captures; the current frame always serialises the latched words.
REQ-027 SHALL register SAMPLE_STB and hold it high for exactly one CLK per capture.

Reset
REQ-028 SHALL, on RESET high, immediately and asynchronously force state IDLE, clear all counters and word registers, and drive all outputs to 0, regardless of an in-progress frame.
REQ-029 SHALL, after RESET is released, behave exactly as IDLE per REQ-015 (EN=1 enters RUN on the next CLK).

Verification
REQ-030 SHALL cover: BCK_DIV=2, EN rising -> SAMPLE_STB same cycle and every 256 CLK after; BCK period 4 CLK; LRCK toggles every 128 CLK.
REQ-031 SHALL cover: GAIN=0, VOL=0, IN_L=0x2000, IN_R=0x7FFF -> left word 0x4000, right word 0xFFFE serialised in slot positions 1..16; positions 0 and 17..31 = 0.
REQ-032 SHALL cover: GAIN=2, IN_L=0x1000, IN_R=0x4000 -> left 0x7FFF, right 0x8000 (saturation).
REQ-033 SHALL cover: VOL=15, IN_L=-5, IN_R=+100 -> left 0xFFFF, right 0x0000; also IN_L changed mid-frame -> no effect until the next SAMPLE_STB.
REQ-034 SHALL cover: EN dropped mid-right-slot -> all outputs 0 on the next CLK; EN re-raised -> SAMPLE_STB same cycle, LRCK=0, DATA=0.
REQ-035 SHALL cover: RESET asserted asynchronously mid-frame between CLK edges -> outputs 0 without waiting for a CLK edge; after release with EN=1, capture on the first CLK edge.

Source files
------------

// File: rtl/gs_i2s_tx.sv
// I2S transmitter for the GS sound stage: samples a stereo pair, applies gain with
// saturation and volume attenuation, and serialises 16-bit words in a 64-BCK frame.
module gs_i2s_tx #(
    parameter int BCK_DIV = 4,
    parameter int GAIN    = 0
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        EN,
    input  logic [14:0] IN_L,
    input  logic [14:0] IN_R,
    input  logic [3:0]  VOL,
    output logic        I2S_BCK,
    output logic        I2S_LRCK,
    output logic        I2S_DATA,
    output logic        SAMPLE_STB,
    output logic        state_dbg_o
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    localparam logic [7:0]         DIV_LAST = 8'(BCK_DIV - 1);
    localparam logic signed [17:0] SAT_HI   = 18'sd32767;
    localparam logic signed [17:0] SAT_LO   = -18'sd32768;

    state_t      state_q;
    logic [7:0]  div_q;
    logic [5:0]  n_q;
    logic [15:0] word_l_q;
    logic [15:0] word_r_q;
    logic        bck_q;
    logic        lrck_q;
    logic        data_q;
    logic        stb_q;

    logic [5:0]  n_d;
    logic        wrap_d;
    logic [15:0] scl_l;
    logic [15:0] scl_r;
    logic [15:0] word_l_d;
    logic [15:0] word_r_d;

    // Sample is widened to 18 bits so that a shift by up to 2 cannot overflow
    // before the saturation compare.
    function automatic logic [15:0] scale(input logic [14:0] smp, input logic [3:0] vol);
        logic signed [17:0] s;
        logic signed [17:0] g;
        logic signed [15:0] c;
        s = {{2{smp[14]}}, smp, 1'b0};
        g = s <<< GAIN;
        if (g > SAT_HI) begin
            c = 16'sh7FFF;
        end else if (g < SAT_LO) begin
            c = 16'sh8000;
        end else begin
            c = g[15:0];
        end
        return c >>> vol;
    endfunction

    function automatic logic slot_bit(input logic [5:0] n, input logic [15:0] wl,
                                      input logic [15:0] wr);
        logic [4:0]  p;
        logic [15:0] w;
        logic [3:0]  idx;
        p   = n[4:0];
        w   = n[5] ? wr : wl;
        idx = 4'(5'd16 - p);
        if (p >= 5'd1 && p <= 5'd16) begin
            return w[idx];
        end
        return 1'b0;
    endfunction

    always_comb begin
        scl_l    = scale(IN_L, VOL);
        scl_r    = scale(IN_R, VOL);
        n_d      = n_q + 6'd1;
        wrap_d   = (n_q == 6'd63);
        word_l_d = wrap_d ? scl_l : word_l_q;
        word_r_d = wrap_d ? scl_r : word_r_q;
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q  <= S_IDLE;
            div_q    <= '0;
            n_q      <= '0;
            word_l_q <= '0;
            word_r_q <= '0;
            bck_q    <= 1'b0;
            lrck_q   <= 1'b0;
            data_q   <= 1'b0;
            stb_q    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    div_q  <= '0;
                    n_q    <= '0;
                    bck_q  <= 1'b0;
                    lrck_q <= 1'b0;
                    data_q <= 1'b0;
                    if (EN) begin
                        state_q  <= S_RUN;
                        word_l_q <= scl_l;
                        word_r_q <= scl_r;
                        stb_q    <= 1'b1;
                    end else begin
                        word_l_q <= '0;
                        word_r_q <= '0;
                        stb_q    <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (!EN) begin
                        state_q  <= S_IDLE;
                        div_q    <= '0;
                        n_q      <= '0;
                        word_l_q <= '0;
                        word_r_q <= '0;
                        bck_q    <= 1'b0;
                        lrck_q   <= 1'b0;
                        data_q   <= 1'b0;
                        stb_q    <= 1'b0;
                    end else begin
                        stb_q <= 1'b0;
                        if (div_q == DIV_LAST) begin
                            div_q <= '0;
                            bck_q <= ~bck_q;
                            // Falling BCK: advance slot, present its bit, recapture on wrap.
                            if (bck_q) begin
                                n_q    <= n_d;
                                lrck_q <= n_d[5];
                                data_q <= slot_bit(n_d, word_l_d, word_r_d);
                                if (wrap_d) begin
                                    word_l_q <= scl_l;
                                    word_r_q <= scl_r;
                                    stb_q    <= 1'b1;
                                end
                            end
                        end else begin
                            div_q <= div_q + 8'd1;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign I2S_BCK     = bck_q;
    assign I2S_LRCK    = lrck_q;
    assign I2S_DATA    = data_q;
    assign SAMPLE_STB  = stb_q;
    assign state_dbg_o = (state_q == S_RUN);

endmodule

// File: tb/tb_gs_i2s_tx.sv
// Directed bench for gs_i2s_tx: two instances (GAIN=0 and GAIN=2) share inputs and
// BCK_DIV=2; frames are sampled slot by slot and compared to hand-derived words.
module tb_gs_i2s_tx;

    localparam int BCK_DIV = 2;
    localparam int SLOT    = 2 * BCK_DIV;

    logic        CLK   = 1'b0;
    logic        RESET = 1'b1;
    logic        EN    = 1'b0;
    logic [14:0] IN_L  = 15'h2000;
    logic [14:0] IN_R  = 15'h7FFF;
    logic [3:0]  VOL   = 4'd0;

    logic bck0, lr0, dat0, stb0, st0;
    logic bck2, lr2, dat2, stb2, st2;

    int total = 0;
    int bad   = 0;

    logic [63:0] d0_bits, d2_bits, lr0_bits, lr2_bits;

    always #5 CLK = ~CLK;

    gs_i2s_tx #(.BCK_DIV(BCK_DIV), .GAIN(0)) dut0 (
        .CLK(CLK), .RESET(RESET), .EN(EN), .IN_L(IN_L), .IN_R(IN_R), .VOL(VOL),
        .I2S_BCK(bck0), .I2S_LRCK(lr0), .I2S_DATA(dat0), .SAMPLE_STB(stb0),
        .state_dbg_o(st0)
    );

    gs_i2s_tx #(.BCK_DIV(BCK_DIV), .GAIN(2)) dut2 (
        .CLK(CLK), .RESET(RESET), .EN(EN), .IN_L(IN_L), .IN_R(IN_R), .VOL(VOL),
        .I2S_BCK(bck2), .I2S_LRCK(lr2), .I2S_DATA(dat2), .SAMPLE_STB(stb2),
        .state_dbg_o(st2)
    );

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // Slot p in 1..16 carries bit 16-p of the left word, slot 32+p of the right word.
    function automatic logic [63:0] frame_bits(input logic [15:0] l, input logic [15:0] r);
        logic [63:0] f;
        f = '0;
        for (int p = 1; p <= 16; p++) begin
            f[p]      = l[16-p];
            f[32 + p] = r[16-p];
        end
        return f;
    endfunction

    // Advances at least one negedge, then stops at the negedge showing dut0's strobe.
    task automatic wait_stb(output int cyc);
        cyc = 0;
        do begin
            @(negedge CLK);
            cyc++;
        end while (!stb0 && cyc < 600);
        if (!stb0) begin
            total++;
            bad++;
            $display("FAIL wait_stb no strobe within %0d cycles", cyc);
        end
    endtask

    task automatic grab_frame(input int chg_slot, input logic [14:0] chg_l);
        int cyc;
        wait_stb(cyc);
        for (int k = 0; k < 64; k++) begin
            if (k == chg_slot) IN_L = chg_l;
            d0_bits[k]  = dat0;
            d2_bits[k]  = dat2;
            lr0_bits[k] = lr0;
            lr2_bits[k] = lr2;
            if (k < 63) repeat (SLOT) @(negedge CLK);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge CLK);
        total++;
        if ({bck0, lr0, dat0, stb0, st0} !== 5'b0) begin
            bad++;
            $display("FAIL reset_dut0 got=%b exp=00000", {bck0, lr0, dat0, stb0, st0});
        end
        total++;
        if ({bck2, lr2, dat2, stb2, st2} !== 5'b0) begin
            bad++;
            $display("FAIL reset_dut2 got=%b exp=00000", {bck2, lr2, dat2, stb2, st2});
        end
        EN = 1'b1;
        repeat (3) @(negedge CLK);
        total++;
        if ({bck0, lr0, dat0, stb0, st0} !== 5'b0) begin
            bad++;
            $display("FAIL reset_hold_en got=%b exp=00000", {bck0, lr0, dat0, stb0, st0});
        end
        EN    = 1'b0;
        RESET = 1'b0;
        repeat (2) @(negedge CLK);
        total++;
        if ({bck0, lr0, dat0, stb0, st0} !== 5'b0) begin
            bad++;
            $display("FAIL idle_en_low got=%b exp=00000", {bck0, lr0, dat0, stb0, st0});
        end
    endtask

    task automatic test_timing();
        logic [9:0] tv;
        logic exp_stb, exp_bck, exp_lr;
        EN = 1'b1;
        for (int t = 0; t < 520; t++) begin
            @(negedge CLK);
            tv      = 10'(t);
            exp_stb = (t % 256 == 0);
            exp_bck = tv[1];
            exp_lr  = tv[7];
            total++;
            if ({stb0, bck0, lr0} !== {exp_stb, exp_bck, exp_lr}) begin
                bad++;
                $display("FAIL timing_dut0 t=%0d got stb/bck/lr=%b exp=%b",
                         t, {stb0, bck0, lr0}, {exp_stb, exp_bck, exp_lr});
            end
            total++;
            if ({stb2, bck2, lr2} !== {exp_stb, exp_bck, exp_lr}) begin
                bad++;
                $display("FAIL timing_dut2 t=%0d got stb/bck/lr=%b exp=%b",
                         t, {stb2, bck2, lr2}, {exp_stb, exp_bck, exp_lr});
            end
        end
    endtask

    task automatic test_gain0();
        logic [63:0] e0, e2;
        grab_frame(-1, 15'h0);
        e0 = frame_bits(16'h4000, 16'hFFFE);
        e2 = frame_bits(16'h7FFF, 16'hFFF8);
        total++;
        if (d0_bits !== e0) begin
            bad++;
            $display("FAIL gain0_data_dut0 got=%h exp=%h", d0_bits, e0);
        end
        total++;
        if (d2_bits !== e2) begin
            bad++;
            $display("FAIL gain0_data_dut2 got=%h exp=%h", d2_bits, e2);
        end
        total++;
        if (lr0_bits !== 64'hFFFFFFFF_00000000) begin
            bad++;
            $display("FAIL lrck_stream_dut0 got=%h exp=ffffffff00000000", lr0_bits);
        end
        total++;
        if (lr2_bits !== 64'hFFFFFFFF_00000000) begin
            bad++;
            $display("FAIL lrck_stream_dut2 got=%h exp=ffffffff00000000", lr2_bits);
        end
    endtask

    task automatic test_saturation();
        logic [63:0] e0, e2;
        @(negedge CLK);
        IN_L = 15'h1000;
        IN_R = 15'h4000;
        grab_frame(-1, 15'h0);
        e0 = frame_bits(16'h2000, 16'h8000);
        e2 = frame_bits(16'h7FFF, 16'h8000);
        total++;
        if (d0_bits !== e0) begin
            bad++;
            $display("FAIL sat_data_dut0 got=%h exp=%h", d0_bits, e0);
        end
        total++;
        if (d2_bits !== e2) begin
            bad++;
            $display("FAIL sat_data_dut2 got=%h exp=%h", d2_bits, e2);
        end
    endtask

    task automatic test_vol_hold();
        logic [63:0] e_neg, e_zero;
        @(negedge CLK);
        IN_L = 15'h7FFB;
        IN_R = 15'd100;
        VOL  = 4'd15;
        e_neg  = frame_bits(16'hFFFF, 16'h0000);
        e_zero = frame_bits(16'h0000, 16'h0000);
        grab_frame(5, 15'h2000);
        total++;
        if (d0_bits !== e_neg) begin
            bad++;
            $display("FAIL vol15_hold_dut0 got=%h exp=%h", d0_bits, e_neg);
        end
        total++;
        if (d2_bits !== e_neg) begin
            bad++;
            $display("FAIL vol15_hold_dut2 got=%h exp=%h", d2_bits, e_neg);
        end
        grab_frame(-1, 15'h0);
        total++;
        if (d0_bits !== e_zero) begin
            bad++;
            $display("FAIL vol15_next_dut0 got=%h exp=%h", d0_bits, e_zero);
        end
        total++;
        if (d2_bits !== e_zero) begin
            bad++;
            $display("FAIL vol15_next_dut2 got=%h exp=%h", d2_bits, e_zero);
        end
    endtask

    task automatic test_en_drop();
        int cyc;
        @(negedge CLK);
        IN_L = 15'h2000;
        IN_R = 15'h7FFF;
        VOL  = 4'd0;
        wait_stb(cyc);
        wait_stb(cyc);
        repeat (162) @(negedge CLK);
        total++;
        if ({lr0, dat0, bck0} !== 3'b111) begin
            bad++;
            $display("FAIL drop_pre got lr/dat/bck=%b exp=111", {lr0, dat0, bck0});
        end
        EN = 1'b0;
        @(negedge CLK);
        total++;
        if ({bck0, lr0, dat0, stb0, st0} !== 5'b0) begin
            bad++;
            $display("FAIL drop_idle_dut0 got=%b exp=00000", {bck0, lr0, dat0, stb0, st0});
        end
        total++;
        if ({bck2, lr2, dat2, stb2, st2} !== 5'b0) begin
            bad++;
            $display("FAIL drop_idle_dut2 got=%b exp=00000", {bck2, lr2, dat2, stb2, st2});
        end
        repeat (3) @(negedge CLK);
        EN = 1'b1;
        @(negedge CLK);
        total++;
        if ({stb0, lr0, dat0, bck0, st0} !== 5'b10001) begin
            bad++;
            $display("FAIL reraise got stb/lr/dat/bck/st=%b exp=10001",
                     {stb0, lr0, dat0, bck0, st0});
        end
        wait_stb(cyc);
        total++;
        if (cyc !== 256) begin
            bad++;
            $display("FAIL reraise_period got=%0d exp=256", cyc);
        end
    endtask

    task automatic test_async_reset();
        int cyc;
        wait_stb(cyc);
        repeat (162) @(negedge CLK);
        total++;
        if ({lr0, dat0, bck0} !== 3'b111) begin
            bad++;
            $display("FAIL areset_pre got lr/dat/bck=%b exp=111", {lr0, dat0, bck0});
        end
        #1 RESET = 1'b1;
        #1;
        total++;
        if ({bck0, lr0, dat0, stb0, st0} !== 5'b0) begin
            bad++;
            $display("FAIL areset_dut0 got=%b exp=00000", {bck0, lr0, dat0, stb0, st0});
        end
        total++;
        if ({bck2, lr2, dat2, stb2, st2} !== 5'b0) begin
            bad++;
            $display("FAIL areset_dut2 got=%b exp=00000", {bck2, lr2, dat2, stb2, st2});
        end
        @(negedge CLK);
        RESET = 1'b0;
        @(negedge CLK);
        total++;
        if ({stb0, lr0, dat0, bck0, st0} !== 5'b10001) begin
            bad++;
            $display("FAIL areset_release got stb/lr/dat/bck/st=%b exp=10001",
                     {stb0, lr0, dat0, bck0, st0});
        end
        wait_stb(cyc);
        total++;
        if (cyc !== 256) begin
            bad++;
            $display("FAIL areset_period got=%0d exp=256", cyc);
        end
    endtask

    initial begin
        test_reset();
        test_timing();
        test_gain0();
        test_saturation();
        test_vol_hold();
        test_en_drop();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
